// File: rtl/riscv_pkg.sv
// Shared core definitions: funct3 access encodings and the data-memory bridge FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_BYTE       = 3'b000;
    localparam logic [2:0] F3_HALFWORD   = 3'b001;
    localparam logic [2:0] F3_WORD       = 3'b010;
    localparam logic [2:0] F3_BYTE_U     = 3'b100;
    localparam logic [2:0] F3_HALFWORD_U = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    function automatic logic f3_is_load(input logic [2:0] f3);
        return (f3 == F3_BYTE) || (f3 == F3_HALFWORD) || (f3 == F3_WORD) ||
               (f3 == F3_BYTE_U) || (f3 == F3_HALFWORD_U);
    endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/halfword out of a bus word and sign- or zero-extends it.
module load_extender
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  f3,
    output logic [31:0] result
);

    logic [15:0] low_half;

    assign low_half = 16'(word >> {offset, 3'b000});

    always_comb begin
        result = '0;
        case (f3)
            F3_BYTE:       result = {{24{low_half[7]}}, low_half[7:0]};
            F3_BYTE_U:     result = {24'd0, low_half[7:0]};
            F3_HALFWORD:   result = {{16{low_half[15]}}, low_half};
            F3_HALFWORD_U: result = {16'd0, low_half};
            F3_WORD:       result = word;
            default:       result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Runs one core load/store as a single request/response on the data-memory bus,
// stalling the core until the access completes, errors or times out.
module data_mem_bridge
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_f3,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mem_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        access_err_q, access_err_d;
    logic [31:0] ext_word;
    logic        timeout_hit;

    load_extender u_load_extender (
        .word   (mem_rdata),
        .offset (off_q),
        .f3     (f3_q),
        .result (ext_word)
    );

    assign stall       = req_valid && (state_q != ST_DONE);
    assign cnt_inc     = cnt_q + 1'b1;
    // cnt_inc counts the current REQ/RESP cycle, so the limit lands on the TIMEOUT_CYCLES-th one
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        f3_d         = f3_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        access_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    if ((req_be == 4'b0000) || (!req_we && !f3_is_load(req_f3))) begin
                        state_d      = ST_DONE;
                        access_err_d = 1'b1;
                        load_data_d  = '0;
                    end else begin
                        state_d     = ST_REQ;
                        off_d       = req_addr[1:0];
                        f3_d        = req_f3;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    state_d      = ST_DONE;
                    mem_req_d    = 1'b0;
                    access_err_d = 1'b1;
                    load_data_d  = '0;
                end else if (mem_gnt) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    state_d      = ST_DONE;
                    access_err_d = 1'b1;
                    load_data_d  = '0;
                end else if (mem_rvalid) begin
                    state_d = ST_DONE;
                    if (!mem_we_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = ext_word;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            access_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            access_err_q <= access_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign access_err = access_err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: directed and random accesses, scoreboard of retire outcomes.
module tb_data_mem_bridge;

    localparam int TO = 8;

    logic        clk, rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        stall, load_valid, access_err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        lv;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    data_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_f3(req_f3), .req_be(req_be), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .access_err(access_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load semantics in plain arithmetic
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        int unsigned sh, b, h;
        sh = w >> (8 * int'(off));
        b  = sh % 256;
        h  = sh % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            3'b101:  return h;
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Enables a load/store decoder would produce; 0 marks a misaligned access
    function automatic logic [3:0] dec_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 4'b0001 << off;
            3'b001, 3'b101: return off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
            3'b010:         return (off == 2'd0) ? 4'b1111 : 4'b0000;
            default:        return 4'b1111;
        endcase
    endfunction

    // g = REQ cycles with gnt low before the grant, r = RESP cycles before rvalid
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int g, input int r);
        exp_t e;
        bit   mis, mem_ok, req_seen;
        int   d_exp, d_act;
        mis = (be == 4'b0000) || (!we && !f3_legal(f3));
        if (mis) begin
            e = '{lv: 1'b0, err: 1'b1, data: 32'd0};
            d_exp = 1;
        end else if (TO != 0 && g + r + 2 >= TO) begin
            e = '{lv: 1'b0, err: 1'b1, data: 32'd0};
            d_exp = 1 + TO;
        end else begin
            e = '{lv: !we, err: 1'b0, data: we ? 32'd0 : ref_load(rdata, addr[1:0], f3)};
            d_exp = g + r + 3;
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_f3 = f3;
        req_be = be; req_wdata = wdata;
        exp_q.push_back(e);
        mem_ok = 1'b1; req_seen = 1'b0; d_act = -1;
        for (int c = 0; c < 400 && d_act < 0; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            mem_gnt    = !mis && (c == 1 + g);
            mem_rvalid = !mis && (c == 2 + g + r);
            mem_rdata  = (c == 2 + g + r) ? rdata : $urandom;
            @(negedge clk);
            if (mem_req) begin
                req_seen = 1'b1;
                if (mem_addr !== {addr[31:2], 2'b00} || mem_be !== be ||
                    mem_we !== we || mem_wdata !== wdata) mem_ok = 1'b0;
            end
            if (!stall) d_act = c;
        end
        chk("done_cycle", d_act, d_exp);
        chk("mem_fields", {31'd0, mem_ok}, 32'd1);
        chk("mem_req_seen", {31'd0, req_seen}, {31'd0, !mis});
        #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_retire actual=retire required=none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_valid", {31'd0, load_valid}, {31'd0, e.lv});
                    chk("access_err", {31'd0, access_err}, {31'd0, e.err});
                    if (e.lv || e.err) chk("load_data", load_data, e.data);
                end
            end else if (load_valid || access_err) begin
                total++; bad++;
                $display("FAIL spurious_pulse actual=lv%0b/err%0b required=0/0 at %0t",
                         load_valid, access_err, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        we;
        logic [31:0] addr;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_f3 = '0;
        req_be = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_flags", {28'd0, mem_we, load_valid, access_err, stall}, 32'd0);
        chk("rst_data", load_data | mem_wdata | {28'd0, mem_be}, 32'd0);
        req_valid = 1'b1; #1;
        chk("rst_stall_follows_req", {31'd0, stall}, 32'd1);
        req_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // stray bus handshakes while idle must be ignored
        repeat (3) begin
            @(posedge clk); #1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            chk("stray_no_req", {31'd0, mem_req}, 32'd0);
        end
        #6; mem_gnt = 1'b0; mem_rvalid = 1'b0;

        do_txn(1'b0, 32'h0000_1003, 3'b000, 4'b1000, 32'h0, 32'h8012_3456, 0, 0);
        do_txn(1'b0, 32'h0000_2002, 3'b101, 4'b1100, 32'h0, 32'hBEEF_1234, 0, 0);
        do_txn(1'b0, 32'h0000_2002, 3'b001, 4'b1100, 32'h0, 32'hBEEF_1234, 1, 1);
        do_txn(1'b1, 32'h0000_3000, 3'b010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 3, 0);
        do_txn(1'b0, 32'h0000_4001, 3'b001, 4'b0000, 32'h0, 32'h0, 0, 0);
        do_txn(1'b0, 32'h0000_0040, 3'b010, 4'b1111, 32'h0, 32'h1234_5678, 0, 1000);
        do_txn(1'b0, 32'h0000_0044, 3'b010, 4'b1111, 32'h0, 32'h1234_5678, 1000, 0);
        do_txn(1'b0, 32'h0000_0048, 3'b011, 4'b1111, 32'h0, 32'h0, 0, 0);
        idle(2);

        // reset while a load waits for its grant
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5004; req_f3 = 3'b010;
        req_be = 4'b1111; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_async", {31'd0, mem_req}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("reset_addr", mem_addr, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_txn(1'b0, 32'h0000_5004, 3'b010, 4'b1111, 32'h0, 32'hCAFE_F00D, 1, 2);

        for (int i = 0; i < 40; i++) begin
            we  = $urandom_range(0, 1);
            off = 2'($urandom_range(0, 3));
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 6))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
                    4: f3 = 3'b101; 5: f3 = 3'b011; default: f3 = 3'b111;
                endcase
            end
            addr = {$urandom} & 32'hFFFF_FFFC | {30'd0, off};
            do_txn(we, addr, f3, dec_be(f3, off), $urandom, $urandom,
                   $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
